// File: rtl/computie_bus_pkg.sv
// Shared types and entry-format constants for the CompuTie bus trace capture block.
package computie_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_POST,
    ST_DONE,
    ST_DUMP
  } state_t;

  localparam int FLAG_W          = 8;
  localparam int FLAG_RW_BIT     = 7;
  localparam int FLAG_TRIG_BIT   = 6;
  localparam int FLAG_NODATA_BIT = 5;

  function automatic logic [FLAG_W-1:0] make_flags(input logic rw, input logic trig,
                                                   input logic nodata);
    logic [FLAG_W-1:0] f;
    f                  = '0;
    f[FLAG_RW_BIT]     = rw;
    f[FLAG_TRIG_BIT]   = trig;
    f[FLAG_NODATA_BIT] = nodata;
    return f;
  endfunction

endpackage

// File: rtl/computie_bus_trace_ram.sv
// Simple dual-port trace memory: one synchronous write port, one registered read port.
module computie_bus_trace_ram #(
  parameter int WIDTH  = 72,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/computie_bus_trace_capture.sv
// Triggered CompuTie bus trace: circular capture with pre/post-trigger history,
// dumped oldest-first as a byte stream after the window freezes.
module computie_bus_trace_capture
  import computie_bus_pkg::*;
#(
  parameter int BITWIDTH     = 32,
  parameter int DEPTH_LOG2   = 8,
  parameter int POST_DEFAULT = 16
) (
  input  logic                  comm_clock,
  input  logic                  comm_reset_n,
  input  logic                  arm,
  input  logic                  trigger_ext,
  input  logic [BITWIDTH-1:0]   trig_mask,
  input  logic [BITWIDTH-1:0]   trig_match,
  input  logic                  trig_on_write,
  input  logic [DEPTH_LOG2-1:0] post_count,
  output logic                  capture_done,
  input  logic                  dump_start,
  output logic                  dump_end,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  input  logic                  cb_clk,
  input  logic                  cb_addr_strobe,
  input  logic                  cb_data_strobe,
  input  logic                  cb_read_write,
  input  logic [BITWIDTH-1:0]   cb_addr_data_bus
);

  localparam int ENTRY_W     = 2 * BITWIDTH + FLAG_W;
  localparam int ENTRY_BYTES = 1 + 2 * (BITWIDTH / 8);
  localparam int CNT_W       = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(1 << DEPTH_LOG2);
  localparam logic [3:0]       LAST_BYTES = 4'(ENTRY_BYTES - 1);

  // The bus is sampled on comm_clock only; its own clock carries no information here.
  logic w_unused_cb_clk;
  assign w_unused_cb_clk = cb_clk;

  logic [1:0]            r_as_sync, r_ds_sync, r_rw_sync;
  logic                  r_as_prev, r_ds_prev;
  logic [BITWIDTH-1:0]   r_bus_s1, r_bus_s2;
  logic [BITWIDTH-1:0]   r_addr, r_data;
  logic                  r_rw, r_data_seen;
  state_t                r_state;
  logic [DEPTH_LOG2-1:0] r_ptr, r_rd_addr, r_post_lat, r_remaining;
  logic [CNT_W-1:0]      r_count, r_ent_left;
  logic                  r_ext_pend, r_arm_d, r_dstart_d;
  logic                  r_capture_done, r_dump_end, r_out_valid;
  logic [7:0]            r_out_data;
  logic [1:0]            r_hdr_left;
  logic [3:0]            r_byte_left;
  logic [ENTRY_W-1:0]    r_shift;

  logic                  w_as_fall, w_as_rise, w_ds_fall;
  logic                  w_match, w_trig, w_commit, w_adv;
  logic [ENTRY_W-1:0]    w_wdata, w_rdata;
  logic [15:0]           w_count16;

  always_ff @(posedge comm_clock or negedge comm_reset_n) begin
    if (!comm_reset_n) begin
      r_as_sync <= 2'b11;
      r_ds_sync <= 2'b11;
      r_rw_sync <= 2'b00;
      r_as_prev <= 1'b1;
      r_ds_prev <= 1'b1;
    end else begin
      r_as_sync <= {r_as_sync[0], cb_addr_strobe};
      r_ds_sync <= {r_ds_sync[0], cb_data_strobe};
      r_rw_sync <= {r_rw_sync[0], cb_read_write};
      r_as_prev <= r_as_sync[1];
      r_ds_prev <= r_ds_sync[1];
    end
  end

  // Bus value travels through the same two stages as the strobes, so it lines up with the edges.
  always_ff @(posedge comm_clock) begin
    r_bus_s1 <= cb_addr_data_bus;
    r_bus_s2 <= r_bus_s1;
    if (w_as_fall) begin
      r_addr <= r_bus_s2;
      r_rw   <= r_rw_sync[1];
    end
    if (w_ds_fall) r_data <= r_bus_s2;
  end

  assign w_as_fall = r_as_prev & ~r_as_sync[1];
  assign w_as_rise = ~r_as_prev & r_as_sync[1];
  assign w_ds_fall = r_ds_prev & ~r_ds_sync[1];

  assign w_match  = (((r_addr ^ trig_match) & trig_mask) == '0) && (!r_rw || !trig_on_write);
  assign w_trig   = (r_state == ST_PRE) && (r_ext_pend || trigger_ext || w_match);
  assign w_commit = w_as_rise && arm && ((r_state == ST_PRE) || (r_state == ST_POST));
  assign w_wdata  = {make_flags(r_rw, w_trig, !r_data_seen), r_addr,
                     r_data_seen ? r_data : '0};

  computie_bus_trace_ram #(
    .WIDTH  (ENTRY_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .i_clk   (comm_clock),
    .i_we    (w_commit),
    .i_waddr (r_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_addr),
    .o_rdata (w_rdata)
  );

  assign w_count16 = 16'(r_count);
  assign w_adv     = (r_state == ST_DUMP) && (!r_out_valid || out_ready);

  always_ff @(posedge comm_clock or negedge comm_reset_n) begin
    if (!comm_reset_n) begin
      r_state        <= ST_IDLE;
      r_ptr          <= '0;
      r_count        <= '0;
      r_post_lat     <= DEPTH_LOG2'(POST_DEFAULT);
      r_remaining    <= '0;
      r_ext_pend     <= 1'b0;
      r_arm_d        <= 1'b0;
      r_dstart_d     <= 1'b0;
      r_data_seen    <= 1'b0;
      r_capture_done <= 1'b0;
      r_dump_end     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_data     <= 8'h00;
      r_rd_addr      <= '0;
      r_hdr_left     <= 2'd0;
      r_byte_left    <= 4'd0;
      r_ent_left     <= '0;
    end else begin
      r_arm_d    <= arm;
      r_dstart_d <= dump_start;
      r_dump_end <= 1'b0;
      if (w_as_fall)      r_data_seen <= 1'b0;
      else if (w_ds_fall) r_data_seen <= 1'b1;
      if (w_commit) begin
        r_ptr <= r_ptr + 1'b1;
        if (r_count != CNT_FULL) r_count <= r_count + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (arm && !r_arm_d) begin
            r_state    <= ST_PRE;
            r_ptr      <= '0;
            r_count    <= '0;
            r_post_lat <= post_count;
            r_ext_pend <= 1'b0;
          end
        end
        ST_PRE: begin
          if (!arm) begin
            r_state <= ST_IDLE;
          end else begin
            if (trigger_ext) r_ext_pend <= 1'b1;
            if (w_commit && w_trig) begin
              r_ext_pend <= 1'b0;
              if (r_post_lat == '0) begin
                r_state        <= ST_DONE;
                r_capture_done <= 1'b1;
              end else begin
                r_state     <= ST_POST;
                r_remaining <= r_post_lat;
              end
            end
          end
        end
        ST_POST: begin
          if (!arm) begin
            r_state <= ST_IDLE;
          end else if (w_commit) begin
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == DEPTH_LOG2'(1)) begin
              r_state        <= ST_DONE;
              r_capture_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!arm) begin
            r_state        <= ST_IDLE;
            r_capture_done <= 1'b0;
          end else if (dump_start && !r_dstart_d) begin
            r_state     <= ST_DUMP;
            r_rd_addr   <= r_ptr - r_count[DEPTH_LOG2-1:0];
            r_hdr_left  <= 2'd2;
            r_byte_left <= 4'd0;
            r_ent_left  <= r_count;
          end
        end
        ST_DUMP: begin
          // Next entry is read well ahead: header and each entry take >= 2 bytes of time.
          if (w_adv) begin
            if (r_hdr_left != 2'd0) begin
              r_out_data  <= (r_hdr_left == 2'd2) ? w_count16[15:8] : w_count16[7:0];
              r_out_valid <= 1'b1;
              r_hdr_left  <= r_hdr_left - 1'b1;
            end else if (r_byte_left != 4'd0) begin
              r_out_data  <= r_shift[ENTRY_W-1 -: 8];
              r_out_valid <= 1'b1;
              r_byte_left <= r_byte_left - 1'b1;
            end else if (r_ent_left != '0) begin
              r_out_data  <= w_rdata[ENTRY_W-1 -: 8];
              r_out_valid <= 1'b1;
              r_byte_left <= LAST_BYTES;
              r_ent_left  <= r_ent_left - 1'b1;
              r_rd_addr   <= r_rd_addr + 1'b1;
            end else begin
              r_out_valid    <= 1'b0;
              r_dump_end     <= 1'b1;
              r_capture_done <= 1'b0;
              r_state        <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge comm_clock) begin
    if (w_adv && (r_hdr_left == 2'd0)) begin
      if (r_byte_left != 4'd0)    r_shift <= r_shift << 8;
      else if (r_ent_left != '0)  r_shift <= w_rdata << 8;
    end
  end

  assign capture_done = r_capture_done;
  assign dump_end     = r_dump_end;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;

endmodule

// File: tb/tb_computie_bus_trace_capture.sv
// Bench for computie_bus_trace_capture: bus cycles are modelled as a list of entries,
// and the expected dump is derived from the last min(n, depth) entries of that list.
module tb_computie_bus_trace_capture;

  localparam int BW    = 32;
  localparam int DL    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arm, trigger_ext, trig_on_write, dump_start, out_ready;
  logic [BW-1:0] trig_mask, trig_match, bus;
  logic [DL-1:0] post_count;
  logic          capture_done, dump_end, out_valid;
  logic [7:0]    out_data;
  logic          cb_clk, as_n, ds_n, rw_n;

  int n_tests = 0;
  int n_fail  = 0;
  logic [71:0] model_q[$];
  logic [7:0]  exp_bytes[$];

  always #5 clk = ~clk;

  computie_bus_trace_capture #(
    .BITWIDTH(BW), .DEPTH_LOG2(DL), .POST_DEFAULT(1)
  ) dut (
    .comm_clock(clk), .comm_reset_n(rst_n), .arm(arm), .trigger_ext(trigger_ext),
    .trig_mask(trig_mask), .trig_match(trig_match), .trig_on_write(trig_on_write),
    .post_count(post_count), .capture_done(capture_done), .dump_start(dump_start),
    .dump_end(dump_end), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cb_clk(cb_clk), .cb_addr_strobe(as_n), .cb_data_strobe(ds_n), .cb_read_write(rw_n),
    .cb_addr_data_bus(bus)
  );

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm_up(input logic [DL-1:0] p);
    arm = 1'b0;
    wait_clk(2);
    post_count = p;
    model_q.delete();
    arm = 1'b1;
    wait_clk(2);
  endtask

  task automatic pulse_ext();
    trigger_ext = 1'b1;
    wait_clk(1);
    trigger_ext = 1'b0;
  endtask

  // One bus cycle; the entry it should produce is appended to the model list.
  task automatic do_cycle(input logic [31:0] a, input logic [31:0] d, input logic rw,
                          input logic has, input logic trig);
    bus = a; rw_n = rw;
    wait_clk(2);
    as_n = 1'b0;
    wait_clk(3);
    if (has) begin
      bus = d;
      wait_clk(2);
      ds_n = 1'b0;
      wait_clk(3);
      ds_n = 1'b1;
      wait_clk(2);
    end
    as_n = 1'b1;
    wait_clk(5);
    model_q.push_back({rw, trig, ~has, 5'b0, a, (has ? d : 32'h0)});
  endtask

  function automatic logic spec_match(input logic [31:0] a, input logic rw);
    return (((a ^ trig_match) & trig_mask) == 32'h0) && (rw == 1'b0 || !trig_on_write);
  endfunction

  function automatic void build_expected();
    int n, w;
    exp_bytes.delete();
    n = model_q.size();
    w = (n > DEPTH) ? DEPTH : n;
    exp_bytes.push_back(8'(w >> 8));
    exp_bytes.push_back(8'(w));
    for (int i = n - w; i < n; i++)
      for (int b = 8; b >= 0; b--) exp_bytes.push_back(model_q[i][b*8 +: 8]);
  endfunction

  task automatic run_dump(input bit rand_ready);
    logic [7:0] got[$];
    logic [7:0] held;
    bit         stalled;
    int         ends, cyc, after, lim;
    stalled = 0; ends = 0; cyc = 0; after = -1; held = 8'h00;
    dump_start = 1'b1;
    wait_clk(1);
    dump_start = 1'b0;
    while (cyc < 3000 && !(after >= 0 && cyc - after > 6)) begin
      if (dump_end) begin
        ends++;
        if (after < 0) after = cyc;
      end
      if (stalled) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%0b data=%02h, required valid=1 data=%02h",
                   out_valid, out_data, held);
        end
      end
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      stalled   = out_valid && !out_ready;
      held      = out_data;
      if (out_valid && out_ready) got.push_back(out_data);
      wait_clk(1);
      cyc++;
    end
    out_ready = 1'b0;
    n_tests++;
    if (after < 0) begin
      n_fail++;
      $display("FAIL dump_timeout: no dump_end within %0d cycles", cyc);
    end
    n_tests++;
    if (got.size() !== exp_bytes.size()) begin
      n_fail++;
      $display("FAIL dump_len: got %0d bytes, required %0d", got.size(), exp_bytes.size());
    end
    lim = (got.size() < exp_bytes.size()) ? got.size() : exp_bytes.size();
    for (int i = 0; i < lim; i++) begin
      n_tests++;
      if (got[i] !== exp_bytes[i]) begin
        n_fail++;
        $display("FAIL dump_byte[%0d]: got %02h, required %02h", i, got[i], exp_bytes[i]);
      end
    end
    n_tests++;
    if (ends !== 1) begin
      n_fail++;
      $display("FAIL dump_end_pulses: got %0d, required 1", ends);
    end
    n_tests++;
    if (capture_done !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_dump_idle: done=%0b valid=%0b, required 0 0", capture_done, out_valid);
    end
  endtask

  task automatic test_reset();
    wait_clk(3);
    n_tests++;
    if ({capture_done, dump_end, out_valid, out_data} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %03h, required 000", {capture_done, dump_end, out_valid, out_data});
    end
    rst_n = 1'b1;
    wait_clk(2);
    trig_mask = 32'hFFFFFFFF; trig_match = 32'hFFFF0000; trig_on_write = 1'b0;
    arm_up(2'd0);
    for (int i = 0; i < 3; i++) do_cycle(32'h11111110 + i, 32'h1, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    wait_clk(2);
    n_tests++;
    if ({capture_done, dump_end, out_valid, out_data} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got %03h, required 000", {capture_done, dump_end, out_valid, out_data});
    end
    arm = 1'b0;
    rst_n = 1'b1;
    wait_clk(2);
    arm_up(2'd0);
    do_cycle(32'h01020304, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0);
    pulse_ext();
    do_cycle(32'h0A0B0C0D, 32'h5A5A5A5A, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if (capture_done !== 1'b1) begin
      n_fail++;
      $display("FAIL rearm_done: got %0b, required 1", capture_done);
    end
    build_expected();
    run_dump(1'b0);
  endtask

  task automatic test_directed();
    trig_mask = 32'hFFFFFFFF; trig_match = 32'h12345678; trig_on_write = 1'b0;
    arm_up(2'd1);
    do_cycle(32'h2020FFFF, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b0);
    do_cycle(32'h12345678, 32'h55555555, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if (capture_done !== 1'b0) begin
      n_fail++;
      $display("FAIL directed_post_pending: got %0b, required 0", capture_done);
    end
    do_cycle(32'h87654321, 32'h0F0F0F0F, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (capture_done !== 1'b1) begin
      n_fail++;
      $display("FAIL directed_done: got %0b, required 1", capture_done);
    end
    build_expected();
    run_dump(1'b0);
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    logic        rw;
    trig_mask = 32'hFFFFFFFF; trig_match = 32'h0000BEEF; trig_on_write = 1'b0;
    arm_up(2'd0);
    for (int i = 1; i <= 10; i++) begin
      a = $urandom;
      while (a == trig_match) a = $urandom;
      if (i == 10) a = trig_match;
      rw = 1'($urandom_range(0, 1));
      do_cycle(a, $urandom, rw, 1'b1, spec_match(a, rw));
      if (i == 9) begin
        n_tests++;
        if (capture_done !== 1'b0) begin
          n_fail++;
          $display("FAIL wrap_early_done: got %0b, required 0", capture_done);
        end
      end
    end
    n_tests++;
    if (capture_done !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_done: got %0b, required 1", capture_done);
    end
    build_expected();
    run_dump(1'b0);
  endtask

  task automatic test_on_write();
    trig_mask = 32'hFFFFFFFF; trig_match = 32'hCAFE0000; trig_on_write = 1'b1;
    arm_up(2'd1);
    do_cycle(32'hCAFE0000, 32'h11112222, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (capture_done !== 1'b0) begin
      n_fail++;
      $display("FAIL onwrite_read_ignored: got %0b, required 0", capture_done);
    end
    do_cycle(32'hCAFE0000, 32'h33334444, 1'b0, 1'b1, 1'b1);
    do_cycle(32'h13572468, 32'h0, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (capture_done !== 1'b1) begin
      n_fail++;
      $display("FAIL onwrite_done: got %0b, required 1", capture_done);
    end
    build_expected();
    run_dump(1'b1);
    trig_on_write = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          npre, npost;
    trig_mask = 32'hFFFFFFFF; trig_on_write = 1'b0;
    for (int it = 0; it < 4; it++) begin
      trig_match = $urandom;
      npre  = $urandom_range(1, 6);
      npost = $urandom_range(1, 3);
      arm_up(DL'(npost));
      for (int i = 0; i < npre; i++) begin
        a = $urandom;
        while (a == trig_match) a = $urandom;
        if (i == npre - 1) pulse_ext();
        do_cycle(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), i == npre - 1);
      end
      for (int j = 0; j < npost; j++)
        do_cycle($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0);
      n_tests++;
      if (capture_done !== 1'b1) begin
        n_fail++;
        $display("FAIL random_done[%0d]: got %0b, required 1", it, capture_done);
      end
      build_expected();
      run_dump(1'b1);
    end
  endtask

  task automatic test_abort();
    bit saw_valid;
    trig_mask = 32'hFFFFFFFF; trig_match = 32'hFFFF0000;
    arm_up(2'd3);
    do_cycle(32'h00000001, 32'h2, 1'b1, 1'b1, 1'b0);
    pulse_ext();
    do_cycle(32'h00000003, 32'h4, 1'b1, 1'b1, 1'b1);
    do_cycle(32'h00000005, 32'h6, 1'b0, 1'b1, 1'b0);
    arm = 1'b0;
    wait_clk(3);
    out_ready = 1'b1;
    dump_start = 1'b1;
    wait_clk(1);
    dump_start = 1'b0;
    saw_valid = 0;
    for (int i = 0; i < 20; i++) begin
      saw_valid |= out_valid;
      wait_clk(1);
    end
    out_ready = 1'b0;
    n_tests++;
    if (saw_valid || capture_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ignored: valid_seen=%0b done=%0b, required 0 0", saw_valid, capture_done);
    end
  endtask

  task automatic test_reset_mid_dump();
    trig_mask = 32'hFFFFFFFF; trig_match = 32'hFFFF0000;
    arm_up(2'd0);
    pulse_ext();
    do_cycle(32'h00000010, 32'h20, 1'b1, 1'b1, 1'b1);
    out_ready = 1'b0;
    dump_start = 1'b1;
    wait_clk(1);
    dump_start = 1'b0;
    wait_clk(4);
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL dump_started: got %0b, required 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || capture_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_dump: valid=%0b done=%0b, required 0 0", out_valid, capture_done);
    end
    wait_clk(2);
    arm = 1'b0;
    rst_n = 1'b1;
    wait_clk(2);
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; trigger_ext = 1'b0; trig_on_write = 1'b0;
    dump_start = 1'b0; out_ready = 1'b0; post_count = '0;
    trig_mask = '0; trig_match = '0; bus = '0;
    cb_clk = 1'b0; as_n = 1'b1; ds_n = 1'b1; rw_n = 1'b1;
    test_reset();
    test_directed();
    test_wrap();
    test_on_write();
    test_random();
    test_abort();
    test_reset_mid_dump();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
